// File: rtl/ram_port_arbiter_if.sv
// rtl/ram_port_arbiter_if.sv - CPU, DMA and RAM-side signals of the RAM port arbiter
interface ram_port_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_lock;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic              lock_abort;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic              ram_write;
    logic [DATA_W-1:0] ram_dout;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
        input  ram_dout,
        output cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, lock_abort,
        output rdata, ram_addr, ram_din, ram_write
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
        output ram_dout,
        input  cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid, lock_abort,
        input  rdata, ram_addr, ram_din, ram_write
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - single-port RAM arbiter: CPU priority, DMA anti-starvation and timed bus lock
module ram_port_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 4,
    parameter int LOCK_MAX = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    ram_port_arbiter_if.slave bus
);
    localparam logic [3:0]        WAIT_SAT  = 4'(MAX_WAIT);
    localparam logic [7:0]        LOCK_LAST = 8'(LOCK_MAX - 1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
    localparam logic [DATA_W-1:0] DATA_ZERO = '0;

    typedef enum logic {
        ARB,
        LOCKED
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] wait_cnt, wait_nxt;
    logic [7:0] lock_cnt, lock_nxt;
    logic       abort_nxt;
    logic       cpu_win, dma_win;
    logic       cpu_gnt_i, dma_gnt_i;

    // Grants are forced low while reset is asserted, so no access leaks out during reset
    assign cpu_gnt_i = rst_n & cpu_win;
    assign dma_gnt_i = rst_n & dma_win;

    assign bus.cpu_gnt   = cpu_gnt_i;
    assign bus.dma_gnt   = dma_gnt_i;
    assign bus.ram_addr  = !rst_n    ? ADDR_ZERO :
                           dma_gnt_i ? bus.dma_addr : bus.cpu_addr;
    assign bus.ram_din   = !rst_n    ? DATA_ZERO :
                           dma_gnt_i ? bus.dma_wdata : bus.cpu_wdata;
    assign bus.ram_write = dma_gnt_i ? bus.dma_we : (cpu_gnt_i & bus.cpu_we);
    assign bus.rdata     = bus.ram_dout;

    // Arbitration decision, next state, and counter updates
    always_comb begin
        state_nxt = state;
        cpu_win   = 1'b0;
        dma_win   = 1'b0;
        wait_nxt  = wait_cnt;
        lock_nxt  = 8'd0;
        abort_nxt = 1'b0;
        case (state)
            ARB: begin
                if (bus.dma_req && (wait_cnt == WAIT_SAT)) begin
                    dma_win = 1'b1;
                end else if (bus.cpu_req) begin
                    cpu_win = 1'b1;
                end else if (bus.dma_req) begin
                    dma_win = 1'b1;
                end
                if (dma_win && bus.dma_lock) begin
                    state_nxt = LOCKED;
                end
                if (bus.dma_req && !dma_win) begin
                    wait_nxt = (wait_cnt == WAIT_SAT) ? wait_cnt : wait_cnt + 4'd1;
                end else begin
                    wait_nxt = 4'd0;
                end
            end
            LOCKED: begin
                dma_win = bus.dma_req;
                if (!bus.dma_lock) begin
                    state_nxt = ARB;
                end else if (lock_cnt == LOCK_LAST) begin
                    // Timed-out lock: DMA loses its accumulated priority and re-arbitrates
                    state_nxt = ARB;
                    abort_nxt = 1'b1;
                    wait_nxt  = 4'd0;
                end else begin
                    lock_nxt = lock_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = ARB;
            end
        endcase
    end

    // State, counters, read-valid tags and abort pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ARB;
            wait_cnt       <= 4'd0;
            lock_cnt       <= 8'd0;
            bus.cpu_rvalid <= 1'b0;
            bus.dma_rvalid <= 1'b0;
            bus.lock_abort <= 1'b0;
        end else begin
            state          <= state_nxt;
            wait_cnt       <= wait_nxt;
            lock_cnt       <= lock_nxt;
            bus.cpu_rvalid <= cpu_gnt_i & ~bus.cpu_we;
            bus.dma_rvalid <= dma_gnt_i & ~bus.dma_we;
            bus.lock_abort <= abort_nxt;
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - self-checking bench for ram_port_arbiter against a behavioural model
module tb_ram_port_arbiter;
    localparam int AW = 10;
    localparam int DW = 16;
    localparam int MW = 4;
    localparam int LM = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW), .LOCK_MAX(LM)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // RAM macro: synchronous, one-cycle read latency, contents reloaded on reset
    logic [DW-1:0] mem [0:1023];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 1024; i++) mem[i] <= DW'(i * 7 + 3);
        end else begin
            if (bus.ram_write) mem[bus.ram_addr] <= bus.ram_din;
            bus.ram_dout <= mem[bus.ram_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit            m_locked;
    int            m_wait;
    int            m_lock_len;
    logic          m_cpu_rv, m_dma_rv, m_abort;
    logic [DW-1:0] m_rd;
    logic [DW-1:0] exp_mem [0:1023];

    // Last observed DUT outputs
    logic          o_cpu_gnt, o_dma_gnt, o_abort, o_write;
    logic [DW-1:0] o_din;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked   = 1'b0;
        m_wait     = 0;
        m_lock_len = 0;
        m_cpu_rv   = 1'b0;
        m_dma_rv   = 1'b0;
        m_abort    = 1'b0;
        m_rd       = '0;
        for (int i = 0; i < 1024; i++) exp_mem[i] = DW'(i * 7 + 3);
    endtask

    task automatic reset_outputs_check(input string tag);
        chk({tag, "_cpu_gnt"}, bus.cpu_gnt, 0);
        chk({tag, "_dma_gnt"}, bus.dma_gnt, 0);
        chk({tag, "_ram_write"}, bus.ram_write, 0);
        chk({tag, "_ram_addr"}, bus.ram_addr, 0);
        chk({tag, "_ram_din"}, bus.ram_din, 0);
        chk({tag, "_cpu_rvalid"}, bus.cpu_rvalid, 0);
        chk({tag, "_dma_rvalid"}, bus.dma_rvalid, 0);
        chk({tag, "_lock_abort"}, bus.lock_abort, 0);
    endtask

    // One clock cycle: inputs were set at the falling edge; check, then advance the model
    task automatic step();
        logic          e_cpu, e_dma, e_we, nab;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_din;
        #1;
        if (m_locked) begin
            e_dma = bus.dma_req;
            e_cpu = 1'b0;
        end else begin
            e_dma = bus.dma_req && (m_wait >= MW || !bus.cpu_req);
            e_cpu = bus.cpu_req && !e_dma;
        end
        e_addr = e_dma ? bus.dma_addr : bus.cpu_addr;
        e_din  = e_dma ? bus.dma_wdata : bus.cpu_wdata;
        e_we   = e_dma ? bus.dma_we : (e_cpu && bus.cpu_we);
        chk("cpu_gnt", bus.cpu_gnt, e_cpu);
        chk("dma_gnt", bus.dma_gnt, e_dma);
        chk("ram_addr", bus.ram_addr, e_addr);
        chk("ram_din", bus.ram_din, e_din);
        chk("ram_write", bus.ram_write, e_we);
        chk("cpu_rvalid", bus.cpu_rvalid, m_cpu_rv);
        chk("dma_rvalid", bus.dma_rvalid, m_dma_rv);
        chk("lock_abort", bus.lock_abort, m_abort);
        if (m_cpu_rv || m_dma_rv) chk("rdata", bus.rdata, m_rd);
        o_cpu_gnt = bus.cpu_gnt;
        o_dma_gnt = bus.dma_gnt;
        o_abort   = bus.lock_abort;
        o_write   = bus.ram_write;
        o_din     = bus.ram_din;
        nab = 1'b0;
        if (m_locked) begin
            m_lock_len++;
            if (!bus.dma_lock) begin
                m_locked = 1'b0;
            end else if (m_lock_len >= LM) begin
                m_locked = 1'b0;
                nab      = 1'b1;
                m_wait   = 0;
            end
        end else begin
            if (bus.dma_req && !e_dma) m_wait = (m_wait + 1 > MW) ? MW : m_wait + 1;
            else m_wait = 0;
            if (e_dma && bus.dma_lock) begin
                m_locked   = 1'b1;
                m_lock_len = 0;
            end
        end
        m_cpu_rv = e_cpu && !bus.cpu_we;
        m_dma_rv = e_dma && !bus.dma_we;
        if (m_cpu_rv || m_dma_rv) m_rd = exp_mem[e_addr];
        if (e_we) exp_mem[e_addr] = e_din;
        m_abort = nab;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, n, n_first, n_last, aborts;
        rst_n         = 1'b1;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 10'h3FF;
        bus.cpu_wdata = 16'hFFFF;
        bus.dma_req   = 1'b1;
        bus.dma_we    = 1'b1;
        bus.dma_addr  = 10'h3FE;
        bus.dma_wdata = 16'h1234;
        bus.dma_lock  = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        #12;
        reset_outputs_check("reset");
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b0;
        bus.cpu_we  = 1'b0;
        bus.dma_we  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // CPU-only reads
        bus.cpu_addr = 10'h010;
        bus.cpu_req  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t1_cpu_gnt", o_cpu_gnt, 1);
            chk("t1_dma_gnt", o_dma_gnt, 0);
        end
        bus.cpu_req = 1'b0;
        step();

        // Idle
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t6_idle_write", o_write, 0);
        end

        // Continuous contention: CPU x4 then DMA x1
        bus.cpu_req = 1'b1;
        bus.dma_req = 1'b1;
        bus.dma_addr = 10'h011;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t2_dma_gnt", o_dma_gnt, (i % 5) == 4);
            chk("t2_cpu_gnt", o_cpu_gnt, (i % 5) != 4);
        end
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b0;
        step();

        // DMA locked write burst against a requesting CPU
        bus.cpu_req   = 1'b1;
        bus.cpu_addr  = 10'h020;
        bus.dma_req   = 1'b1;
        bus.dma_we    = 1'b1;
        bus.dma_lock  = 1'b1;
        bus.dma_addr  = 10'h100;
        bus.dma_wdata = 16'hA5A0;
        k = 0; n = 0; n_first = 0; n_last = 0;
        while (k < 4 && n < 20) begin
            step();
            if (o_dma_gnt) begin
                chk("t3_din", o_din, 16'hA5A0 + k);
                chk("t3_write", o_write, 1);
                if (k == 0) n_first = n;
                else chk("t3_cpu_blocked", o_cpu_gnt, 0);
                n_last = n;
                k++;
                bus.dma_addr  = AW'(10'h100 + k);
                bus.dma_wdata = DW'(16'hA5A0 + k);
            end
            n++;
        end
        chk("t3_writes", k, 4);
        chk("t3_consecutive", n_last - n_first, 3);
        bus.dma_req  = 1'b0;
        bus.dma_lock = 1'b0;
        step();
        step();
        chk("t3_cpu_after", o_cpu_gnt, 1);
        bus.cpu_req = 1'b0;
        bus.dma_we  = 1'b0;
        step();

        // Lock timeout
        bus.dma_req  = 1'b1;
        bus.dma_lock = 1'b1;
        bus.dma_addr = 10'h101;
        step();
        bus.cpu_req = 1'b1;
        aborts = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (o_abort) begin
                aborts++;
                chk("t4_cpu_wins", o_cpu_gnt, 1);
                chk("t4_abort_time", i, 8);
            end
        end
        chk("t4_abort_count", aborts, 1);
        bus.cpu_req  = 1'b0;
        bus.dma_req  = 1'b0;
        bus.dma_lock = 1'b0;
        step();

        // Reset during a lock with a read in flight
        bus.dma_req  = 1'b1;
        bus.dma_lock = 1'b1;
        bus.dma_addr = 10'h102;
        step();
        step();
        bus.cpu_req = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        reset_outputs_check("t5");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        bus.dma_req  = 1'b0;
        bus.dma_lock = 1'b0;
        bus.cpu_addr = 10'h030;
        step();
        chk("t5_cpu_first", o_cpu_gnt, 1);
        bus.cpu_req = 1'b0;
        step();

        // Randomised traffic; each master holds its request until granted
        o_cpu_gnt = 1'b0;
        o_dma_gnt = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!(bus.cpu_req && !o_cpu_gnt)) begin
                bus.cpu_req   = 1'($urandom_range(0, 1));
                bus.cpu_we    = 1'($urandom_range(0, 1));
                bus.cpu_addr  = AW'($urandom_range(0, 15));
                bus.cpu_wdata = DW'($urandom);
            end
            if (!(bus.dma_req && !o_dma_gnt)) begin
                bus.dma_req   = 1'($urandom_range(0, 1));
                bus.dma_we    = 1'($urandom_range(0, 1));
                bus.dma_addr  = AW'($urandom_range(0, 15));
                bus.dma_wdata = DW'($urandom);
            end
            bus.dma_lock = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
